reply_timingctrl: RTL and testbench

- Responder-side half-duplex RS422 turnaround controller for the slave end of the command link.
- After a valid command has been received, it waits a bus turnaround guard time and asserts the line-driver enable. It then pre-drives idle, starts the reply UART, and holds the driver through the last stop bit before releasing the bus.
- Reply data that is not ready within the reply window is dropped, so the initiator's 1 ms no-reply timeout is never violated.
- Sits between the command decoder / reply formatter and the UART transmitter and RS422 transceiver.

---
 rtl/reply_timingctrl.sv | 129 ++++++++++++
 tb/tb_reply_timingctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reply_timingctrl.sv
// Slave-side RS422 reply turnaround controller: guard time, driver enable,
// pre-drive idle, reply start, post-stop hold, reply window and watchdog.
module reply_timingctrl #(
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned TURN_CYC  = 600,
  parameter int unsigned PRE_CYC   = 24,
  parameter int unsigned HOLD_CYC  = 120,
  parameter int unsigned REPLY_TMO = 9600,
  parameter int unsigned TX_TMO    = 60000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic rx_busy,
  input  logic tx_req,
  input  logic tx_en,
  output logic tx_start,
  output logic DE,
  output logic busy,
  output logic timeout,
  output logic abort
);

  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(REPLY_TMO - 1);
  localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(TX_TMO - 1);

  typedef enum logic [5:0] {
    IDLE  = 6'b000001,
    ARMED = 6'b000010,
    PRE   = 6'b000100,
    START = 6'b001000,
    SEND  = 6'b010000,
    HOLD  = 6'b100000
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tx_en_d;
  logic             done;
  logic             timeout_d, abort_d;
  logic             de_d, busy_d, tx_start_d;

  // Last stop bit has left the transmitter.
  assign done = tx_en_d & ~tx_en;

  // Next state, one-cycle status pulses and next values of the registered outputs.
  always_comb begin
    state_d   = state_q;
    timeout_d = 1'b0;
    abort_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) state_d = ARMED;
      end
      ARMED: begin
        if (rx_busy) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (tx_req && (cnt_q >= TURN_LAST)) begin
          state_d = PRE;
        end else if (cnt_q == TMO_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
      end
      PRE: begin
        if (rx_busy) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end else if (cnt_q == PRE_LAST) begin
          state_d = START;
        end
      end
      START: state_d = SEND;
      SEND: begin
        if (done) begin
          state_d = HOLD;
        end else if (cnt_q == TX_LAST) begin
          state_d = IDLE;
          abort_d = 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    de_d       = (state_d == PRE) || (state_d == START) ||
                 (state_d == SEND) || (state_d == HOLD);
    busy_d     = (state_d != IDLE);
    tx_start_d = (state_d == START);

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, counter and output registers; reset drops the driver at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      tx_en_d  <= 1'b0;
      DE       <= 1'b0;
      busy     <= 1'b0;
      tx_start <= 1'b0;
      timeout  <= 1'b0;
      abort    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx_en_d  <= tx_en;
      DE       <= de_d;
      busy     <= busy_d;
      tx_start <= tx_start_d;
      timeout  <= timeout_d;
      abort    <= abort_d;
    end
  end

endmodule

// File: tb/tb_reply_timingctrl.sv
// Scoreboard bench for reply_timingctrl: expected output events are timestamped
// from the timing rules and matched against edges seen by a monitor.
module tb_reply_timingctrl;

  localparam int unsigned CNT_W     = 16;
  localparam int unsigned TURN_CYC  = 600;
  localparam int unsigned PRE_CYC   = 24;
  localparam int unsigned HOLD_CYC  = 120;
  localparam int unsigned REPLY_TMO = 9600;
  // Shortened watchdog keeps the run short; every other timing is nominal.
  localparam int unsigned TX_TMO    = 3000;

  localparam int K_BUSY_RISE = 0;
  localparam int K_DE_RISE   = 1;
  localparam int K_START     = 2;
  localparam int K_DE_FALL   = 3;
  localparam int K_BUSY_FALL = 4;
  localparam int K_TIMEOUT   = 5;
  localparam int K_ABORT     = 6;

  typedef struct {
    int cyc;
    int kind;
  } ev_t;

  logic clk       = 1'b0;
  logic rst_n     = 1'b0;
  logic cmd_valid = 1'b0;
  logic rx_busy   = 1'b0;
  logic tx_req    = 1'b0;
  logic tx_en     = 1'b0;
  logic tx_start, DE, busy, timeout, abort;

  int  cyc        = 0;
  int  compared   = 0;
  int  mismatched = 0;
  ev_t exp_q[$];

  reply_timingctrl #(
    .CNT_W(CNT_W), .TURN_CYC(TURN_CYC), .PRE_CYC(PRE_CYC),
    .HOLD_CYC(HOLD_CYC), .REPLY_TMO(REPLY_TMO), .TX_TMO(TX_TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .rx_busy(rx_busy),
    .tx_req(tx_req), .tx_en(tx_en), .tx_start(tx_start), .DE(DE),
    .busy(busy), .timeout(timeout), .abort(abort)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic string kname(input int k);
    case (k)
      K_BUSY_RISE: return "busy_rise";
      K_DE_RISE:   return "de_rise";
      K_START:     return "tx_start";
      K_DE_FALL:   return "de_fall";
      K_BUSY_FALL: return "busy_fall";
      K_TIMEOUT:   return "timeout";
      K_ABORT:     return "abort";
      default:     return "none";
    endcase
  endfunction

  // Keep the queue ordered by (cycle, kind) so the monitor only looks at the head.
  function automatic void push(input int c, input int k);
    ev_t e;
    int  i;
    e.cyc  = c;
    e.kind = k;
    i = 0;
    while (i < exp_q.size() &&
           (exp_q[i].cyc < c || (exp_q[i].cyc == c && exp_q[i].kind <= k)))
      i++;
    exp_q.insert(i, e);
  endfunction

  // Monitor: turn output edges/pulses into events and match them against the queue.
  initial begin : monitor
    logic de_p, busy_p;
    int   obs[$];
    de_p   = 1'b0;
    busy_p = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        de_p   = 1'b0;
        busy_p = 1'b0;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          compared++;
          mismatched++;
          $display("FAIL missed_%s: expected at cycle %0d, still absent at cycle %0d",
                   kname(exp_q[0].kind), exp_q[0].cyc, cyc);
          void'(exp_q.pop_front());
        end
        obs.delete();
        if (busy && !busy_p)  obs.push_back(K_BUSY_RISE);
        if (DE && !de_p)      obs.push_back(K_DE_RISE);
        if (tx_start)         obs.push_back(K_START);
        if (!DE && de_p)      obs.push_back(K_DE_FALL);
        if (!busy && busy_p)  obs.push_back(K_BUSY_FALL);
        if (timeout)          obs.push_back(K_TIMEOUT);
        if (abort)            obs.push_back(K_ABORT);
        foreach (obs[i]) begin
          compared++;
          if (exp_q.size() > 0 && exp_q[0].cyc == cyc && exp_q[0].kind == obs[i]) begin
            void'(exp_q.pop_front());
          end else begin
            mismatched++;
            $display("FAIL unexpected_%s: seen at cycle %0d, next expected %s at cycle %0d",
                     kname(obs[i]), cyc,
                     exp_q.size() > 0 ? kname(exp_q[0].kind) : "none",
                     exp_q.size() > 0 ? exp_q[0].cyc : -1);
          end
        end
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
          compared++;
          mismatched++;
          $display("FAIL missing_%s: expected at cycle %0d, not seen",
                   kname(exp_q[0].kind), cyc);
          void'(exp_q.pop_front());
        end
        de_p   = DE;
        busy_p = busy;
      end
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL global_timeout: run exceeded 150000 cycles");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  // One command/reply exchange.
  // d: tx_req rises d cycles after cmd_valid (<0: never); coll: rx_busy pulse
  // offset (<0: none); len: cycles tx_en stays high in SEND (<0: never falls);
  // noise: ignored cmd_valid / rx_busy / tx_en activity sprinkled in.
  task automatic do_txn(input int d, input int coll, input int len, input bit noise);
    int t, ready_c, arm_end, p, s, f, fin, k;
    bit sent;
    cmd_valid = 1'b1;
    t = cyc;
    push(t + 1, K_BUSY_RISE);
    ready_c = -1;
    if (d >= 0) ready_c = t + ((d > int'(TURN_CYC)) ? d : int'(TURN_CYC));
    if (ready_c > t + int'(REPLY_TMO)) ready_c = -1;
    arm_end = (ready_c >= 0) ? ready_c : t + int'(REPLY_TMO);
    p    = ready_c + 1;
    s    = p + int'(PRE_CYC) + 1;
    f    = -1;
    sent = 1'b0;
    if (coll >= 0 && t + coll <= arm_end) begin
      fin = t + coll + 1;
      push(fin, K_BUSY_FALL);
      push(fin, K_ABORT);
    end else if (ready_c < 0) begin
      fin = arm_end + 1;
      push(fin, K_BUSY_FALL);
      push(fin, K_TIMEOUT);
    end else if (coll >= 0 && t + coll <= p + int'(PRE_CYC) - 1) begin
      fin = t + coll + 1;
      push(p, K_DE_RISE);
      push(fin, K_DE_FALL);
      push(fin, K_BUSY_FALL);
      push(fin, K_ABORT);
    end else begin
      sent = 1'b1;
      push(p, K_DE_RISE);
      push(p + int'(PRE_CYC), K_START);
      if (len < 0) begin
        fin = s + int'(TX_TMO);
        push(fin, K_DE_FALL);
        push(fin, K_BUSY_FALL);
        push(fin, K_ABORT);
      end else begin
        f   = s + len;
        fin = f + int'(HOLD_CYC) + 1;
        push(fin, K_DE_FALL);
        push(fin, K_BUSY_FALL);
      end
    end
    while (cyc <= fin + 2) begin
      k = cyc - t;
      cmd_valid = (k == 0) || (noise && coll < 0 && k == 100) ||
                  (noise && sent && (cyc == s + 2 || (f >= 0 && cyc == f + 5)));
      tx_req    = (d >= 0) && (k >= d);
      rx_busy   = (coll >= 0 && k == coll) || (noise && sent && cyc == s + 3);
      tx_en     = (noise && coll < 0 && k >= 10 && k < 13) ||
                  (sent && cyc >= s && ((len < 0) || (cyc < f)));
      tick();
    end
    cmd_valid = 1'b0;
    tx_req    = 1'b0;
    rx_busy   = 1'b0;
    tx_en     = 1'b0;
    repeat (3) tick();
  endtask

  // Reply in progress, then reset pulled in the middle of SEND.
  task automatic reset_mid_send();
    int t;
    cmd_valid = 1'b1;
    tx_req    = 1'b1;
    t = cyc;
    push(t + 1, K_BUSY_RISE);
    push(t + int'(TURN_CYC) + 1, K_DE_RISE);
    push(t + int'(TURN_CYC) + int'(PRE_CYC) + 1, K_START);
    while (cyc < t + 640) begin
      cmd_valid = (cyc == t);
      tx_en     = (cyc >= t + 626);
      tick();
    end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_send_DE", DE, 1'b0);
    chk("rst_mid_send_busy", busy, 1'b0);
    chk("rst_mid_send_tx_start", tx_start, 1'b0);
    chk("rst_mid_send_abort", abort, 1'b0);
    exp_q.delete();
    tx_en  = 1'b0;
    tx_req = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("after_rst_busy", busy, 1'b0);
    chk("after_rst_DE", DE, 1'b0);
  endtask

  initial begin
    repeat (3) tick();
    chk("reset_DE", DE, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_tx_start", tx_start, 1'b0);
    chk("reset_timeout", timeout, 1'b0);
    chk("reset_abort", abort, 1'b0);
    rst_n = 1'b1;
    repeat (2) tick();

    do_txn(0, -1, 100, 1'b0);                          // nominal turnaround
    do_txn(2000, -1, 40, 1'b0);                        // late reply data
    do_txn(-1, -1, 10, 1'b0);                          // no reply: timeout
    do_txn(int'(REPLY_TMO), -1, 20, 1'b0);             // tx_req on the terminal count wins
    do_txn(int'(REPLY_TMO) + 1, -1, 20, 1'b0);         // one cycle too late
    do_txn(0, 300, 50, 1'b0);                          // collision in ARMED
    do_txn(0, int'(TURN_CYC) + 10, 50, 1'b0);          // collision in PRE
    do_txn(0, -1, -1, 1'b1);                           // SEND watchdog, ignored cmd/rx_busy
    do_txn(0, -1, 30, 1'b1);                           // ignored cmd_valid in SEND/HOLD
    reset_mid_send();
    do_txn(0, -1, 60, 1'b0);                           // nominal timing after reset

    for (int i = 0; i < 6; i++) begin
      int sel;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0, 1: do_txn(int'($urandom_range(0, 1200)), -1, int'($urandom_range(5, 300)), 1'b1);
        2:    do_txn(int'($urandom_range(0, 900)), int'($urandom_range(1, 599)), 50, 1'b0);
        default: do_txn(0, int'(TURN_CYC) + 1 + int'($urandom_range(0, 23)), 50, 1'b0);
      endcase
    end

    repeat (5) tick();
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL leftover_events: %0d expected events never seen, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
